// File: rtl/pipe_ir_chain.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ir_chain
// Purpose  : Five-stage instruction-register chain (IF -> ID -> EX -> MEM ->
//            WB) with PC generation, stall bubbles, branch flush, per-stage
//            R/I-type flags and a sticky over-long-stall error flag.
// Revision : 1.0 - initial release
//
// Optional feature macro : PIPE_PERF_CNT_EN
//   When defined, adds stall_cycles / flush_cycles performance counters.
//
// Ports
//   clk            in   1   rising-edge clock
//   reset          in   1   asynchronous, active-low reset
//   stall          in   1   1 = advance, 0 = stall (hold PC/ID, bubble EX)
//   branch_taken   in   1   redirect request (honoured only on advance)
//   branch_target  in  32   redirect PC
//   instr_if       in  32   instruction fetched at pc
//   pc             out 32   fetch address register
//   IRD..IRWB      out 32   ID / EX / MEM / WB instruction registers
//   is_r_type_*    out  1   registered R-type flag per stage
//   is_i_type_*    out  1   registered I-type flag per stage
//   hazard_err     out  1   sticky: stall run exceeded MAX_STALL
//   stall_cycles   out 32   (PIPE_PERF_CNT_EN) count of stall edges
//   flush_cycles   out 32   (PIPE_PERF_CNT_EN) count of honoured branches
// ============================================================================
module pipe_ir_chain #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MAX_STALL = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic [31:0] instr_if,
    output logic [31:0] pc,
    output logic [31:0] IRD,
    output logic [31:0] IREX,
    output logic [31:0] IRMEM,
    output logic [31:0] IRWB,
    output logic        is_r_type_ID,
    output logic        is_r_type_EXE,
    output logic        is_r_type_MEM,
    output logic        is_r_type_WB,
    output logic        is_i_type_ID,
    output logic        is_i_type_EXE,
    output logic        is_i_type_MEM,
    output logic        is_i_type_WB,
`ifdef PIPE_PERF_CNT_EN
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_cycles,
`endif
    output logic        hazard_err
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [31:0] c_PC_STEP   = 32'd4;
    localparam logic [2:0]  c_CNT_MAX   = 3'd7;
    localparam logic [5:0]  c_OP_RTYPE  = 6'h00;
    localparam logic [5:0]  c_OP_J      = 6'h02;
    localparam logic [5:0]  c_OP_JAL    = 6'h03;

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    logic [31:0] r_pc;
    logic [31:0] r_ird;
    logic [31:0] r_irex;
    logic [31:0] r_irmem;
    logic [31:0] r_irwb;
    logic        r_rt_id, r_rt_ex, r_rt_mem, r_rt_wb;
    logic        r_it_id, r_it_ex, r_it_mem, r_it_wb;
    logic [2:0]  r_stall_cnt;
    logic        r_hazard_err;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic        w_advance;     // this edge shifts the whole chain
    logic        w_redirect;    // branch honoured on this edge
    logic        w_dec_r;       // decode of the fetched instruction
    logic        w_dec_i;
    logic [31:0] w_run_next;    // stall-run length after this stall edge
    logic        w_run_exceed;  // this stall edge makes the run too long

    // Type decode of the instruction entering ID. The all-zero NOP is neither
    // type; J/JAL opcodes are excluded from I-type.
    function automatic logic f_is_r_type(input logic [31:0] ins);
        return (ins != 32'd0) && (ins[31:26] == c_OP_RTYPE);
    endfunction

    function automatic logic f_is_i_type(input logic [31:0] ins);
        return (ins != 32'd0) &&
               (ins[31:26] != c_OP_RTYPE) &&
               (ins[31:26] != c_OP_J) &&
               (ins[31:26] != c_OP_JAL);
    endfunction

    always_comb begin
        w_advance    = stall;
        // Branches seen during a stall are dropped; the held ID instruction
        // presents its branch again on the edge where it finally advances.
        w_redirect   = stall & branch_taken;
        w_dec_r      = f_is_r_type(instr_if);
        w_dec_i      = f_is_i_type(instr_if);
        w_run_next   = {29'd0, r_stall_cnt} + 32'd1;
        w_run_exceed = (w_run_next > MAX_STALL);
    end

    // ------------------------------------------------------------------------
    // Fetch PC
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc <= RESET_PC;
        end else if (w_advance) begin
            if (w_redirect) begin
                r_pc <= branch_target;
            end else begin
                r_pc <= r_pc + c_PC_STEP;   // wraps naturally at 2^32
            end
        end
    end

    // ------------------------------------------------------------------------
    // ID stage: load fetched instruction (or flush on redirect), hold on stall
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ird   <= 32'd0;
            r_rt_id <= 1'b0;
            r_it_id <= 1'b0;
        end else if (w_advance) begin
            if (w_redirect) begin
                // Wrong-path fetch is discarded.
                r_ird   <= 32'd0;
                r_rt_id <= 1'b0;
                r_it_id <= 1'b0;
            end else begin
                r_ird   <= instr_if;
                r_rt_id <= w_dec_r;
                r_it_id <= w_dec_i;
            end
        end
    end

    // ------------------------------------------------------------------------
    // EX stage: takes ID on advance, receives a bubble on stall
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_irex  <= 32'd0;
            r_rt_ex <= 1'b0;
            r_it_ex <= 1'b0;
        end else if (w_advance) begin
            r_irex  <= r_ird;
            r_rt_ex <= r_rt_id;
            r_it_ex <= r_it_id;
        end else begin
            r_irex  <= 32'd0;
            r_rt_ex <= 1'b0;
            r_it_ex <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // MEM and WB stages: always shift, stalls only affect the front end
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_irmem  <= 32'd0;
            r_rt_mem <= 1'b0;
            r_it_mem <= 1'b0;
            r_irwb   <= 32'd0;
            r_rt_wb  <= 1'b0;
            r_it_wb  <= 1'b0;
        end else begin
            r_irmem  <= r_irex;
            r_rt_mem <= r_rt_ex;
            r_it_mem <= r_it_ex;
            r_irwb   <= r_irmem;
            r_rt_wb  <= r_rt_mem;
            r_it_wb  <= r_it_mem;
        end
    end

    // ------------------------------------------------------------------------
    // Stall-run monitor: saturating run counter and sticky error flag
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt  <= 3'd0;
            r_hazard_err <= 1'b0;
        end else if (w_advance) begin
            r_stall_cnt <= 3'd0;
        end else begin
            if (r_stall_cnt != c_CNT_MAX) begin
                r_stall_cnt <= r_stall_cnt + 3'd1;
            end
            if (w_run_exceed) begin
                r_hazard_err <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Optional performance counters
    // ------------------------------------------------------------------------
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_cycles;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cycles <= 32'd0;
            r_flush_cycles <= 32'd0;
        end else begin
            if (!w_advance) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (w_redirect) begin
                r_flush_cycles <= r_flush_cycles + 32'd1;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_cycles = r_flush_cycles;
`endif

    // ------------------------------------------------------------------------
    // Outputs: straight from registers
    // ------------------------------------------------------------------------
    assign pc            = r_pc;
    assign IRD           = r_ird;
    assign IREX          = r_irex;
    assign IRMEM         = r_irmem;
    assign IRWB          = r_irwb;
    assign is_r_type_ID  = r_rt_id;
    assign is_r_type_EXE = r_rt_ex;
    assign is_r_type_MEM = r_rt_mem;
    assign is_r_type_WB  = r_rt_wb;
    assign is_i_type_ID  = r_it_id;
    assign is_i_type_EXE = r_it_ex;
    assign is_i_type_MEM = r_it_mem;
    assign is_i_type_WB  = r_it_wb;
    assign hazard_err    = r_hazard_err;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ir_chain.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_ir_chain
// Purpose  : Directed self-checking bench for pipe_ir_chain. Covers reset
//            state, in-order advance, stall bubbles, branch flush, ignored
//            branch during stall, hazard_err threshold and stickiness,
//            asynchronous reset mid-stall, PC wrap and type decode.
//            Perf counters are exercised when PIPE_PERF_CNT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_ir_chain;

    localparam logic [31:0] c_RESET_PC = 32'h0000_0100;

    // Hand-picked instructions: opcode in [31:26]
    localparam logic [31:0] c_A = 32'h0022_0020;   // op 00 -> R-type
    localparam logic [31:0] c_B = 32'h8C22_0004;   // op 23 -> I-type
    localparam logic [31:0] c_C = 32'h0800_0010;   // op 02 -> neither
    localparam logic [31:0] c_D = 32'h0043_2020;   // op 00 -> R-type
    localparam logic [31:0] c_E = 32'h2001_0005;   // op 08 -> I-type

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] instr_if;
    logic [31:0] pc;
    logic [31:0] IRD, IREX, IRMEM, IRWB;
    logic        is_r_type_ID, is_r_type_EXE, is_r_type_MEM, is_r_type_WB;
    logic        is_i_type_ID, is_i_type_EXE, is_i_type_MEM, is_i_type_WB;
    logic        hazard_err;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_cycles;
`endif

    int n_checks;
    int n_errors;

    pipe_ir_chain #(
        .RESET_PC  (c_RESET_PC),
        .MAX_STALL (3)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .instr_if      (instr_if),
        .pc            (pc),
        .IRD           (IRD),
        .IREX          (IREX),
        .IRMEM         (IRMEM),
        .IRWB          (IRWB),
        .is_r_type_ID  (is_r_type_ID),
        .is_r_type_EXE (is_r_type_EXE),
        .is_r_type_MEM (is_r_type_MEM),
        .is_r_type_WB  (is_r_type_WB),
        .is_i_type_ID  (is_i_type_ID),
        .is_i_type_EXE (is_i_type_EXE),
        .is_i_type_MEM (is_i_type_MEM),
        .is_i_type_WB  (is_i_type_WB),
`ifdef PIPE_PERF_CNT_EN
        .stall_cycles  (stall_cycles),
        .flush_cycles  (flush_cycles),
`endif
        .hazard_err    (hazard_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // One rising edge; return 1 time unit later so outputs are settled.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic bt,
                         input logic [31:0] tgt, input logic [31:0] ins);
        stall         = st;
        branch_taken  = bt;
        branch_target = tgt;
        instr_if      = ins;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b0;
        drive(1'b1, 1'b0, 32'd0, 32'd0);
        step();
        step();

        // ---------------- reset state ----------------
        check_val("rst_pc",    pc, c_RESET_PC);
        check_val("rst_ird",   IRD, 32'd0);
        check_val("rst_irwb",  IRWB, 32'd0);
        check_val("rst_flags", {24'd0, is_r_type_ID, is_r_type_EXE,
                   is_r_type_MEM, is_r_type_WB, is_i_type_ID, is_i_type_EXE,
                   is_i_type_MEM, is_i_type_WB}, 32'd0);
        check_val("rst_herr",  {31'd0, hazard_err}, 32'd0);

        // ---------------- 4 advances: A, B, C, D ----------------
        reset = 1'b1;
        drive(1'b1, 1'b0, 32'd0, c_A); step();
        drive(1'b1, 1'b0, 32'd0, c_B); step();
        drive(1'b1, 1'b0, 32'd0, c_C); step();
        drive(1'b1, 1'b0, 32'd0, c_D); step();
        check_val("adv_pc",    pc, c_RESET_PC + 32'd16);
        check_val("adv_ird",   IRD, c_D);
        check_val("adv_irex",  IREX, c_C);
        check_val("adv_irmem", IRMEM, c_B);
        check_val("adv_irwb",  IRWB, c_A);
        check_val("adv_rt_id", {31'd0, is_r_type_ID}, 32'd1);
        check_val("adv_ex_fl", {30'd0, is_r_type_EXE, is_i_type_EXE}, 32'd0);
        check_val("adv_it_mem", {31'd0, is_i_type_MEM}, 32'd1);
        check_val("adv_rt_wb", {31'd0, is_r_type_WB}, 32'd1);

        // ---------------- 2 stall cycles ----------------
        drive(1'b0, 1'b0, 32'd0, c_E); step();
        check_val("st1_pc",    pc, c_RESET_PC + 32'd16);
        check_val("st1_ird",   IRD, c_D);
        check_val("st1_rt_id", {31'd0, is_r_type_ID}, 32'd1);
        check_val("st1_irex",  IREX, 32'd0);
        check_val("st1_ex_fl", {30'd0, is_r_type_EXE, is_i_type_EXE}, 32'd0);
        check_val("st1_irmem", IRMEM, c_C);
        check_val("st1_irwb",  IRWB, c_B);
        step();
        check_val("st2_pc",    pc, c_RESET_PC + 32'd16);
        check_val("st2_ird",   IRD, c_D);
        check_val("st2_irmem", IRMEM, 32'd0);
        check_val("st2_irwb",  IRWB, c_C);

        // ---------------- branch on advance ----------------
        drive(1'b1, 1'b1, 32'h0000_0040, c_E); step();
        check_val("br_pc",     pc, 32'h0000_0040);
        check_val("br_ird",    IRD, 32'd0);
        check_val("br_id_fl",  {30'd0, is_r_type_ID, is_i_type_ID}, 32'd0);
        check_val("br_irex",   IREX, c_D);
        check_val("br_rt_ex",  {31'd0, is_r_type_EXE}, 32'd1);
        check_val("br_irmem",  IRMEM, 32'd0);

        // ---------------- branch ignored during stall; hazard threshold ----
        drive(1'b0, 1'b1, 32'h0000_0080, c_E); step();
        check_val("brst_pc",   pc, 32'h0000_0040);
        drive(1'b0, 1'b0, 32'd0, c_E); step();
        step();
        check_val("herr_3",    {31'd0, hazard_err}, 32'd0);
        step();
        check_val("herr_4",    {31'd0, hazard_err}, 32'd1);
        drive(1'b1, 1'b0, 32'd0, c_E); step();
        check_val("herr_keep", {31'd0, hazard_err}, 32'd1);
        check_val("post_pc",   pc, 32'h0000_0044);
        check_val("post_it_id", {31'd0, is_i_type_ID}, 32'd1);

        // ---------------- asynchronous reset mid-stall ----------------
        drive(1'b0, 1'b0, 32'd0, c_B); step();
        #2 reset = 1'b0;
        #1;
        check_val("arst_pc",   pc, c_RESET_PC);
        check_val("arst_ird",  IRD, 32'd0);
        check_val("arst_irwb", IRWB, 32'd0);
        check_val("arst_flags", {30'd0, is_i_type_ID, is_r_type_MEM}, 32'd0);
        check_val("arst_herr", {31'd0, hazard_err}, 32'd0);

        // ---------------- PC wrap and type decode ----------------
        step();
        reset = 1'b1;
        drive(1'b1, 1'b1, 32'hFFFF_FFFC, c_E); step();
        check_val("wr_pre",    pc, 32'hFFFF_FFFC);
        drive(1'b1, 1'b0, 32'd0, c_B); step();
        check_val("wr_pc",     pc, 32'h0000_0000);
        check_val("dec_b",     {30'd0, is_r_type_ID, is_i_type_ID}, 32'd1);
        drive(1'b1, 1'b0, 32'd0, 32'd0); step();
        check_val("dec_nop",   {30'd0, is_r_type_ID, is_i_type_ID}, 32'd0);
        check_val("nop_pc",    pc, 32'h0000_0004);
        drive(1'b1, 1'b0, 32'd0, c_D); step();
        check_val("dec_d",     {30'd0, is_r_type_ID, is_i_type_ID}, 32'd2);
        drive(1'b1, 1'b0, 32'd0, c_C); step();
        check_val("dec_j",     {30'd0, is_r_type_ID, is_i_type_ID}, 32'd0);
        drive(1'b1, 1'b0, 32'd0, c_B); step();
        check_val("dec_lw",    {30'd0, is_r_type_ID, is_i_type_ID}, 32'd1);

`ifdef PIPE_PERF_CNT_EN
        // ---------------- perf counters ----------------
        reset = 1'b0;
        step();
        check_val("pf_rst_st", stall_cycles, 32'd0);
        check_val("pf_rst_fl", flush_cycles, 32'd0);
        reset = 1'b1;
        drive(1'b0, 1'b1, 32'h0000_0200, c_A); step();   // stall, branch ignored
        drive(1'b0, 1'b0, 32'd0, c_A); step();
        drive(1'b1, 1'b1, 32'h0000_0200, c_A); step();   // flush 1
        drive(1'b0, 1'b0, 32'd0, c_A); step();
        step();
        drive(1'b1, 1'b1, 32'h0000_0300, c_A); step();   // flush 2
        drive(1'b0, 1'b0, 32'd0, c_A); step();           // stall 5
        check_val("pf_stall",  stall_cycles, 32'd5);
        check_val("pf_flush",  flush_cycles, 32'd2);
        #2 reset = 1'b0;
        #1;
        check_val("pf_arst_st", stall_cycles, 32'd0);
        check_val("pf_arst_fl", flush_cycles, 32'd0);
        check_val("pf_arst_pc", pc, c_RESET_PC);
        reset = 1'b1;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
